// File: rtl/adc_ctrl_pkg.sv
// Shared state encoding and default timing for the serial ADC sequencer.
package adc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        SETUP,
        SHIFT,
        HOLD
    } adc_state_e;

    localparam int DEF_CLK_DIV   = 24;
    localparam int DEF_CONV_WAIT = 1024;
    localparam int ACC_W         = 11;

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: half-period tick counter, ADCLK toggle, and a
// count of completed ADCLK periods (incremented on each fall).
module adc_sclk_gen
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       restart_i,
    output logic       sclk_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic [2:0] bits_o
);

    localparam int              HC_W    = $clog2(CLK_DIV);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic            sclk_q, sclk_d;
    logic [2:0]      bits_q, bits_d;
    logic            tick;

    // rise/fall flag the edge on which ADCLK is about to change
    assign tick   = en_i & ~restart_i & (hcnt_q == HC_LAST);
    assign rise_o = tick & ~sclk_q;
    assign fall_o = tick & sclk_q;
    assign sclk_o = sclk_q;
    assign bits_o = bits_q;

    always_comb begin
        hcnt_d = hcnt_q;
        sclk_d = sclk_q;
        bits_d = bits_q;
        if (restart_i) begin
            hcnt_d = '0;
            sclk_d = 1'b0;
            bits_d = 3'd0;
        end else if (en_i) begin
            if (tick) begin
                hcnt_d = '0;
                sclk_d = ~sclk_q;
                if (sclk_q) bits_d = bits_q + 3'd1;
            end else begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
            sclk_q <= 1'b0;
            bits_q <= 3'd0;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Frame sequencer for an 8-bit serial ADC: prime after reset, shift one byte
// per frame, hold CS high for the conversion time, and average 2^n reads.
module adc_seq_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int CONV_WAIT = DEF_CONV_WAIT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       auto_run,
    input  logic [1:0] avg_log2,
    output logic       busy,
    output logic       done,
    output logic [7:0] data,
    output logic       ADCSN,
    output logic       ADCLK,
    input  logic       ADDAT
);

    localparam int CNT_MAX = (CLK_DIV > CONV_WAIT) ? CLK_DIV : CONV_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CONV_WAIT - 1);

    adc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adcsn_q, adcsn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       rem_q, rem_d;
    logic [1:0]       avg_q, avg_d;
    logic             fin_q, fin_d;
    logic             prime_q, prime_d;

    logic             sclk_rise, sclk_fall, launch;
    logic [2:0]       sclk_bits;
    logic [ACC_W-1:0] sum;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk_i    (CLK),
        .rst_i    (RST),
        .en_i     (state_q == SHIFT),
        .restart_i(state_q != SHIFT),
        .sclk_o   (ADCLK),
        .rise_o   (sclk_rise),
        .fall_o   (sclk_fall),
        .bits_o   (sclk_bits)
    );

    assign sum   = acc_q + ACC_W'(sh_q);
    assign ADCSN = adcsn_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign data  = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        adcsn_d = adcsn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        avg_d   = avg_q;
        fin_d   = fin_q;
        prime_d = prime_q;
        launch  = 1'b0;

        if (sclk_rise) sh_d = {sh_q[6:0], ADDAT};

        case (state_q)
            PRIME: begin
                state_d = SETUP;
                cnt_d   = '0;
                prime_d = 1'b1;
                fin_d   = 1'b1;
            end
            IDLE: launch = (start | auto_run) & ~busy_q;
            SETUP: begin
                adcsn_d = 1'b0;
                if (cnt_q == SETUP_LAST) state_d = SHIFT;
            end
            SHIFT: begin
                if (sclk_fall && sclk_bits == 3'd7) begin
                    adcsn_d = 1'b1;
                    state_d = HOLD;
                    cnt_d   = '0;
                    if (!prime_q) begin
                        if (rem_q == 3'd0) begin
                            data_d = 8'(sum >> avg_q);
                            done_d = 1'b1;
                            acc_d  = '0;
                            fin_d  = 1'b1;
                        end else begin
                            acc_d  = sum;
                            rem_d  = rem_q - 3'd1;
                            fin_d  = 1'b0;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    prime_d = 1'b0;
                    if (!fin_q) begin
                        // Next averaged frame: CS falls right as the hold ends,
                        // so the SETUP count resumes one step in.
                        state_d = SETUP;
                        cnt_d   = CNT_W'(1);
                        adcsn_d = 1'b0;
                    end else if (auto_run && !prime_q) begin
                        launch  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = PRIME;
        endcase

        if (launch) begin
            state_d = SETUP;
            cnt_d   = '0;
            busy_d  = 1'b1;
            avg_d   = avg_log2;
            rem_d   = 3'((4'd1 << avg_log2) - 4'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= PRIME;
            cnt_q   <= '0;
            adcsn_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            acc_q   <= '0;
            sh_q    <= 8'h00;
            rem_q   <= 3'd0;
            avg_q   <= 2'd0;
            fin_q   <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adcsn_q <= adcsn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            avg_q   <= avg_d;
            fin_q   <= fin_d;
            prime_q <= prime_d;
        end
    end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl with a previous-conversion ADC model.
module tb_adc_seq_ctrl;

    localparam int D = 4;
    localparam int W = 32;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       auto_run = 1'b0;
    logic [1:0] avg_log2 = 2'd0;
    logic       busy, done, ADCSN, ADCLK, ADDAT;
    logic [7:0] data;

    adc_seq_ctrl #(.CLK_DIV(D), .CONV_WAIT(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .auto_run(auto_run),
        .avg_log2(avg_log2), .busy(busy), .done(done), .data(data),
        .ADCSN(ADCSN), .ADCLK(ADCLK), .ADDAT(ADDAT)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   gaps[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   ndone = 0, nframes = 0, nrise = 0, viol = 0, rise_cyc = 0;
    logic sn_s = 1'b1, ck_s = 1'b0;

    // Per-frame programmed analog values; each frame returns the previous one.
    logic [7:0] prog_init [11] = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h3C,
                                   8'h77, 8'h99, 8'hFF, 8'h00, 8'h00};
    logic [7:0] prog_q[$];
    logic [7:0] conv = 8'h00, sreg = 8'h00;
    logic       sn_p = 1'b1, ck_p = 1'b0;

    assign ADDAT = sreg[7];

    initial forever begin
        @(ADCSN or ADCLK);
        if (ADCSN === 1'b0 && sn_p === 1'b1) begin
            sreg = conv;
            conv = (prog_q.size() > 0) ? prog_q.pop_front() : 8'h00;
        end else if (ADCSN === 1'b0 && ADCLK === 1'b0 && ck_p === 1'b1) begin
            sreg = {sreg[6:0], 1'b0};
        end
        sn_p = ADCSN;
        ck_p = ADCLK;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_done(input logic [7:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_busy_low(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: scoreboard pops on done, plus frame/ADCLK bookkeeping.
    initial forever begin
        @(negedge CLK);
        if (done === 1'b1) begin
            ndone++;
            chk("done_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e_m = exp_q.pop_front();
                chk("done_data", int'(data), int'(e_m.data));
                chk("done_cycle", cyc, e_m.cyc);
            end
        end
        if (ADCSN === 1'b1 && sn_s === 1'b0) rise_cyc = cyc;
        if (ADCSN === 1'b0 && sn_s === 1'b1) begin
            gaps.push_back(cyc - rise_cyc);
            nframes++;
        end
        if (ADCLK === 1'b1 && ck_s === 1'b0) nrise++;
        if (ADCSN === 1'b1 && ADCLK === 1'b1) viol++;
        sn_s = ADCSN;
        ck_s = ADCLK;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   t0, t, r0, d0, f0, g0, drops, seen;
        logic pv;
        for (int i = 0; i < 11; i++) prog_q.push_back(prog_init[i]);

        // Reset state and the prime frame
        repeat (3) @(negedge CLK);
        chk("rst_adcsn", int'(ADCSN), 1);
        chk("rst_adclk", int'(ADCLK), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_data", int'(data), 0);
        RST = 1'b0; t0 = cyc + 1; r0 = nrise; d0 = ndone;
        wait_busy_low(400, t);
        chk("prime_busy_fall", t - t0, 101);
        chk("prime_rises", nrise - r0, 8);
        chk("prime_no_done", ndone - d0, 0);

        // Single read of 0xA5
        @(negedge CLK);
        avg_log2 = 2'd0; start = 1'b1; t0 = cyc + 1;
        expect_done(8'hA5, t0 + 69);
        @(negedge CLK); start = 1'b0;
        wait_busy_low(400, t);
        chk("single_busy_fall", t - t0, 101);

        // Four-read average; avg_log2 changed mid-measurement is ignored
        @(negedge CLK);
        avg_log2 = 2'd2; start = 1'b1; t0 = cyc + 1; f0 = nframes; g0 = gaps.size();
        expect_done(8'h0B, t0 + 69 + 3 * 100);
        @(negedge CLK); start = 1'b0; avg_log2 = 2'd0;
        wait_busy_low(1000, t);
        chk("avg4_busy_fall", t - t0, 401);
        chk("avg4_frames", nframes - f0, 4);
        for (int k = 1; k <= 3; k++) chk("avg4_cs_gap", gaps[g0 + k], W);

        // Start while busy is dropped
        @(negedge CLK);
        start = 1'b1; t0 = cyc + 1; f0 = nframes; d0 = ndone;
        expect_done(8'h3C, t0 + 69);
        @(negedge CLK); start = 1'b0;
        repeat (20) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK); start = 1'b0;
        wait_busy_low(400, t);
        chk("busy_start_busy_fall", t - t0, 101);
        repeat (20) @(negedge CLK);
        chk("busy_start_one_done", ndone - d0, 1);
        chk("busy_start_one_frame", nframes - f0, 1);
        chk("busy_start_idle", int'(busy), 0);

        // Reset during the 4th ADCLK high phase
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK); start = 1'b0;
        seen = 0; pv = ADCLK;
        for (int i = 0; i < 200 && seen < 4; i++) begin
            @(negedge CLK);
            if (ADCLK === 1'b1 && pv === 1'b0) seen++;
            pv = ADCLK;
        end
        chk("rst_mid_fourth_rise", seen, 4);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_adcsn", int'(ADCSN), 1);
        chk("rst_mid_adclk", int'(ADCLK), 0);
        chk("rst_mid_busy", int'(busy), 1);
        chk("rst_mid_data", int'(data), 0);
        RST = 1'b0; t0 = cyc + 1; r0 = nrise; d0 = ndone;
        wait_busy_low(400, t);
        chk("reprime_busy_fall", t - t0, 101);
        chk("reprime_rises", nrise - r0, 8);
        chk("reprime_no_done", ndone - d0, 0);

        // auto_run back-to-back: 0xFF then 0x00, 101 cycles apart
        @(negedge CLK);
        avg_log2 = 2'd0; auto_run = 1'b1; t0 = cyc + 1;
        expect_done(8'hFF, t0 + 69);
        expect_done(8'h00, t0 + 69 + 101);
        drops = 0; seen = 0;
        for (int i = 0; i < 400 && seen < 2; i++) begin
            @(negedge CLK);
            if (busy !== 1'b1) drops++;
            if (done === 1'b1) seen++;
        end
        auto_run = 1'b0;
        chk("auto_two_dones", seen, 2);
        chk("auto_busy_drops", drops, 0);
        wait_busy_low(200, t);
        chk("auto_busy_fall", t - t0, 69 + 101 + W);

        repeat (10) @(negedge CLK);
        chk("adclk_while_cs_high", viol, 0);
        chk("pending_expected", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
